world_map_arbiter: RTL

Shares the single read port of the 128x128x2-bit world map memory between the VGA display path and the Rojobot sensor/bot port. Display reads have priority, and a starvation guard bounds bot latency. It sits between the pixel timing logic (pixel_row/pixel_column) and the map memory, and produces the world_pixel value consumed by the colorizer.

---
 rtl/world_map_pkg.sv | 27 ++
 rtl/world_map_arbiter_if.sv | 36 +++
 rtl/world_map_arbiter_xlate.sv | 23 ++
 rtl/world_map_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/world_map_pkg.sv
// Shared definitions for the world map read-port arbiter.
// Holds the map geometry, the display-to-map scale, the map value
// encodings and the grant-state type used by the arbiter core.
package world_map_pkg;

    localparam int WORLD_DIM   = 128;               // map is WORLD_DIM x WORLD_DIM cells
    localparam int MAP_AW      = 14;                // {row[6:0], col[6:0]}
    localparam int MAP_DW      = 2;                 // bits per map cell
    localparam int DISP_REGION = 512;               // display pixels covered by the map
    localparam int SCALE_SHIFT = 2;                 // 4x4 display pixels per map cell
    localparam int PIX_W       = 10;                // width of pixel_row / pixel_column
    localparam int COORD_W     = $clog2(WORLD_DIM); // 7-bit map row / column

    typedef logic [MAP_AW-1:0] map_addr_t;
    typedef logic [MAP_DW-1:0] map_val_t;

    // Map value encodings; only background is interpreted here.
    localparam map_val_t MAP_BACKGROUND = 2'b00;

    // Owner of the memory read issued in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_BOT  = 2'd2
    } grant_e;

endpackage

// File: rtl/world_map_arbiter_if.sv
// Bus bundle around the world map arbiter.
//   display side : disp_req, disp_row, disp_col -> world_pixel, disp_miss
//   bot side     : bot_req, bot_addr            -> bot_ack, bot_data
//   memory side  : map_en, map_addr             <- map_data
// slave  : the arbiter's view.
// master : the surrounding system (pixel timing, Rojobot, map memory).
interface world_map_arbiter_if #(
    parameter int MISS_W = 16
);
    logic                           disp_req;
    logic [world_map_pkg::PIX_W-1:0] disp_row;
    logic [world_map_pkg::PIX_W-1:0] disp_col;
    world_map_pkg::map_val_t        world_pixel;

    logic                           bot_req;
    world_map_pkg::map_addr_t       bot_addr;
    logic                           bot_ack;
    world_map_pkg::map_val_t        bot_data;

    logic                           map_en;
    world_map_pkg::map_addr_t       map_addr;
    world_map_pkg::map_val_t        map_data;

    logic [MISS_W-1:0]              disp_miss;

    modport slave (
        input  disp_req, disp_row, disp_col, bot_req, bot_addr, map_data,
        output world_pixel, bot_ack, bot_data, map_en, map_addr, disp_miss
    );

    modport master (
        output disp_req, disp_row, disp_col, bot_req, bot_addr, map_data,
        input  world_pixel, bot_ack, bot_data, map_en, map_addr, disp_miss
    );

endinterface

// File: rtl/world_map_arbiter_xlate.sv
// map_addr_xlate: combinational display-pixel to map-cell translation.
//   disp_row, disp_col : pixel coordinates from the timing logic
//   in_region          : pixel lies inside the 512x512 area covered by the map
//   map_addr           : {disp_row[8:2], disp_col[8:2]}
module map_addr_xlate
    import world_map_pkg::*;
(
    input  logic [PIX_W-1:0] disp_row,
    input  logic [PIX_W-1:0] disp_col,
    output logic             in_region,
    output map_addr_t        map_addr
);

    assign in_region = (disp_row < PIX_W'(DISP_REGION)) &&
                       (disp_col < PIX_W'(DISP_REGION));

    // Dropping the low SCALE_SHIFT bits gives the 4x magnification.
    for (genvar gi = 0; gi < COORD_W; gi++) begin : g_coord
        assign map_addr[COORD_W + gi] = disp_row[SCALE_SHIFT + gi];
        assign map_addr[gi]           = disp_col[SCALE_SHIFT + gi];
    end

endmodule

// File: rtl/world_map_arbiter.sv
// world_map_arbiter: shares the single map-memory read port between the
// display path (priority) and the Rojobot bot port (starvation-guarded).
//   sys_clk : system clock, all state on its rising edge
//   sys_rst : asynchronous active-low reset
//   bus     : world_map_arbiter_if.slave (display, bot and memory signals)
// A read granted in cycle N returns map_data in cycle N+1, where it is
// either registered into world_pixel or passed to bot_data with bot_ack.
module world_map_arbiter
    import world_map_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,   // 1..255
    parameter int MISS_W       = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    world_map_arbiter_if.slave bus
);

    logic      in_region;
    map_addr_t disp_addr;

    map_addr_xlate u_xlate (
        .disp_row  (bus.disp_row),
        .disp_col  (bus.disp_col),
        .in_region (in_region),
        .map_addr  (disp_addr)
    );

    grant_e            state_reg, state_next;
    logic              oor_pending_reg, oor_pending_next;
    logic [7:0]        starve_reg, starve_next;
    logic [MISS_W-1:0] miss_reg, miss_next;
    map_val_t          pixel_reg, pixel_next;

    logic guard;
    logic disp_claim;
    logic grant_disp;
    logic grant_bot;
    logic bot_ack;

    assign bot_ack = (state_reg == ST_BOT);
    assign guard   = (starve_reg >= 8'(STARVE_LIMIT));

    // Requests are masked while reset is held so that map_en/map_addr read
    // as zero immediately, not only after the registers have cleared.
    assign disp_claim = sys_rst & bus.disp_req & in_region;
    assign grant_disp = disp_claim & ~guard;
    // The ack cycle never re-grants: the requester has not yet had a chance
    // to drop bot_req or move bot_addr.
    assign grant_bot  = sys_rst & bus.bot_req & ~bot_ack & (~disp_claim | guard);

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg       <= ST_IDLE;
            oor_pending_reg <= 1'b0;
            starve_reg      <= '0;
            miss_reg        <= '0;
            pixel_reg       <= MAP_BACKGROUND;
        end else begin
            state_reg       <= state_next;
            oor_pending_reg <= oor_pending_next;
            starve_reg      <= starve_next;
            miss_reg        <= miss_next;
            pixel_reg       <= pixel_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next       = ST_IDLE;
        oor_pending_next = bus.disp_req & ~in_region;
        starve_next      = starve_reg;
        miss_next        = miss_reg;
        pixel_next       = pixel_reg;

        if (grant_disp) begin
            state_next = ST_DISP;
        end else if (grant_bot) begin
            state_next = ST_BOT;
        end

        if (!bus.bot_req || grant_bot) begin
            starve_next = '0;
        end else if (starve_reg != 8'hFF) begin
            starve_next = starve_reg + 8'd1;
        end

        // An in-region request that lost its slot to the guard.
        if (disp_claim && !grant_disp && (miss_reg != {MISS_W{1'b1}})) begin
            miss_next = miss_reg + 1'b1;
        end

        // Out-of-region requests never touch memory but still complete
        // with background at the normal latency.
        if (state_reg == ST_DISP) begin
            pixel_next = bus.map_data;
        end else if (oor_pending_reg) begin
            pixel_next = MAP_BACKGROUND;
        end
    end

    // Output logic
    always_comb begin
        bus.map_en      = grant_disp | grant_bot;
        bus.map_addr    = '0;
        if (grant_disp) begin
            bus.map_addr = disp_addr;
        end else if (grant_bot) begin
            bus.map_addr = bus.bot_addr;
        end
        bus.bot_ack     = bot_ack;
        bus.bot_data    = bot_ack ? bus.map_data : MAP_BACKGROUND;
        bus.world_pixel = pixel_reg;
        bus.disp_miss   = miss_reg;
    end

endmodule
